inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 140 ++++++++++++++
 tb/tb_inst_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//   Streams bytes into 32-bit instruction words (big-endian) and writes them
//   into an instruction memory at consecutive word addresses starting at 0.
//   While a session is running the CPU is held off via cpu_hold.
//
// Parameters
//   NWORDS      number of words loaded per session (1..64)
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   start       single-cycle request to begin a session (honoured in IDLE only)
//   abort       ends an active session without writing a partial word
//   byte_in     incoming byte
//   byte_valid  byte_in holds a valid byte
//   byte_ready  loader accepts byte_in this cycle
//   we          instruction-memory write strobe (one cycle per word)
//   waddr       instruction-memory word address (holds last written value)
//   wdata       instruction word (holds last written value)
//   busy        session in progress
//   cpu_hold    holds the CPU PC/pipeline while loading
//   done        one-cycle pulse on successful completion
// -----------------------------------------------------------------------------
module inst_loader #(
    parameter int NWORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        we,
    output logic [5:0]  waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [5:0] LAST_WORD = 6'(NWORDS - 1);

    logic [1:0]  state_r;
    logic [1:0]  state_nx_s;
    logic [1:0]  byte_cnt_r;
    logic [5:0]  word_cnt_r;
    // Only the first three bytes need storing; the fourth goes straight
    // into wdata together with them.
    logic [23:0] asm_r;
    logic        xfer_s;
    logic        last_byte_s;

    // A byte moves only in LOAD with valid set; abort wins over the transfer.
    assign xfer_s      = (state_r == S_LOAD) && byte_valid && !abort;
    assign last_byte_s = (byte_cnt_r == 2'd3);

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = S_LOAD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_nx_s = S_IDLE;
                end else if (xfer_s && last_byte_s) begin
                    state_nx_s = S_WRITE;
                end else begin
                    state_nx_s = S_LOAD;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_nx_s = S_IDLE;
                end else if (word_cnt_r == LAST_WORD) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_LOAD;
                end
            end
            S_DONE: begin
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State, counters, byte assembly and the held write address/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            byte_cnt_r <= 2'd0;
            word_cnt_r <= 6'd0;
            asm_r      <= 24'd0;
            waddr      <= 6'd0;
            wdata      <= 32'd0;
        end else begin
            state_r <= state_nx_s;
            if ((state_r == S_IDLE) && start) begin
                byte_cnt_r <= 2'd0;
                word_cnt_r <= 6'd0;
            end else if (xfer_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                asm_r      <= {asm_r[15:0], byte_in};
                // waddr/wdata are loaded as the word completes so they are
                // already valid during the WRITE cycle and hold afterwards.
                if (last_byte_s) begin
                    waddr <= word_cnt_r;
                    wdata <= {asm_r, byte_in};
                end
            end else if ((state_r == S_WRITE) && !abort && (word_cnt_r != LAST_WORD)) begin
                word_cnt_r <= word_cnt_r + 6'd1;
            end
        end
    end

    // Status and strobes decode directly from the state register, so an
    // asynchronous reset clears them immediately and an abort sampled in
    // WRITE still lets that cycle's write complete.
    assign byte_ready = (state_r == S_LOAD);
    assign we         = (state_r == S_WRITE);
    assign busy       = (state_r != S_IDLE);
    assign cpu_hold   = (state_r != S_IDLE);
    assign done       = (state_r == S_DONE);

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start64, abort, byte_valid;
    logic [7:0]  byte_in;

    logic        rdy4, we4, busy4, hold4, done4;
    logic [5:0]  waddr4;
    logic [31:0] wdata4;
    logic        rdy64, we64, busy64, hold64, done64;
    logic [5:0]  waddr64;
    logic [31:0] wdata64;

    inst_loader #(.NWORDS(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy4),
        .we(we4), .waddr(waddr4), .wdata(wdata4), .busy(busy4),
        .cpu_hold(hold4), .done(done4)
    );

    inst_loader #(.NWORDS(64)) u64 (
        .clk(clk), .rst(rst), .start(start64), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy64),
        .we(we64), .waddr(waddr64), .wdata(wdata64), .busy(busy64),
        .cpu_hold(hold64), .done(done64)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit sel64 = 1'b0;

    // Reference model: expected writes {addr, word} in order, per instance.
    logic [37:0] q4[$];
    logic [37:0] q64[$];
    logic [37:0] e4, e64;
    int          wt4[$];
    int          done_cnt4 = 0, done_cnt64 = 0;
    int          wr_cnt4 = 0, wr_cnt64 = 0;
    logic [7:0]  bb[4];
    int          gaps[4];

    logic sel_rdy, sel_busy, sel_hold, sel_done;
    assign sel_rdy  = sel64 ? rdy64  : rdy4;
    assign sel_busy = sel64 ? busy64 : busy4;
    assign sel_hold = sel64 ? hold64 : hold4;
    assign sel_done = sel64 ? done64 : done4;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Write monitors: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (done4 === 1'b1) done_cnt4++;
        if (we4 === 1'b1) begin
            wr_cnt4++;
            wt4.push_back(cyc);
            if (q4.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL u4_spurious_we: got addr %h data %h want no write", waddr4, wdata4);
            end else begin
                e4 = q4.pop_front();
                chk("u4_waddr", 32'(waddr4), 32'(e4[37:32]));
                chk("u4_wdata", wdata4, e4[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (done64 === 1'b1) done_cnt64++;
        if (we64 === 1'b1) begin
            wr_cnt64++;
            if (q64.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL u64_spurious_we: got addr %h data %h want no write", waddr64, wdata64);
            end else begin
                e64 = q64.pop_front();
                chk("u64_waddr", 32'(waddr64), 32'(e64[37:32]));
                chk("u64_wdata", wdata64, e64[31:0]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        if (sel64) start64 = 1'b1;
        else       start4  = 1'b1;
        tick;
        start4  = 1'b0;
        start64 = 1'b0;
    endtask

    // Offer a byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        byte_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick;
        byte_valid = 1'b1;
        byte_in    = b;
        t = 0;
        while ((sel_rdy !== 1'b1) && (t < 50)) begin
            tick;
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_err++;
            $error("FAIL ready_timeout: got byte_ready %b want 1 within 50 cycles", sel_rdy);
        end
        tick;
    endtask

    task automatic send_word(input int addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(bb[i], gaps[i]);
        if (sel64) q64.push_back({addr[5:0], w});
        else       q4.push_back({addr[5:0], w});
    endtask

    task automatic rand_word(input int addr, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            bb[i]   = 8'($urandom);
            gaps[i] = int'($urandom_range(0, maxgap));
        end
        send_word(addr, {bb[0], bb[1], bb[2], bb[3]});
    endtask

    task automatic finish_session(input string tag);
        int t;
        int d0;
        d0 = sel64 ? done_cnt64 : done_cnt4;
        byte_valid = 1'b0;
        t = 0;
        while ((sel_done !== 1'b1) && (t < 20)) begin
            tick;
            t++;
        end
        chk({tag, "_done"}, 32'(sel_done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(sel_busy), 32'd1);
        tick;
        chk({tag, "_busy_after"}, 32'(sel_busy), 32'd0);
        chk({tag, "_hold_after"}, 32'(sel_hold), 32'd0);
        chk({tag, "_done_after"}, 32'(sel_done), 32'd0);
        chk({tag, "_done_pulses"}, 32'((sel64 ? done_cnt64 : done_cnt4) - d0), 32'd1);
        chk({tag, "_pending"}, 32'(sel64 ? q64.size() : q4.size()), 32'd0);
    endtask

    logic [7:0]  dir_bytes [16];
    logic [31:0] dir_words [4];
    int          w0;
    int          d0;

    initial begin
        dir_bytes = '{8'h00, 8'h10, 8'h04, 8'h43, 8'h04, 8'h10, 8'h10, 8'h25,
                      8'h04, 8'h20, 8'h18, 8'hE1, 8'h14, 8'h00, 8'h28, 8'h28};
        dir_words = '{32'h00100443, 32'h04101025, 32'h042018E1, 32'h14002828};

        rst = 1'b1; start4 = 1'b0; start64 = 1'b0; abort = 1'b0;
        byte_valid = 1'b0; byte_in = 8'h00;
        tick; tick;
        chk("rst_we", 32'(we4), 32'd0);
        chk("rst_waddr", 32'(waddr4), 32'd0);
        chk("rst_wdata", wdata4, 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_ready", 32'(rdy4), 32'd0);
        rst = 1'b0;
        tick;

        // Bytes offered while idle are not taken.
        byte_valid = 1'b1; byte_in = 8'hA5;
        tick; tick;
        chk("idle_ready", 32'(rdy4), 32'd0);
        chk("idle_busy", 32'(busy4), 32'd0);
        byte_valid = 1'b0;

        // Directed full load with valid held.
        sel64 = 1'b0;
        wt4.delete();
        pulse_start;
        chk("start_ready", 32'(rdy4), 32'd1);
        chk("start_hold", 32'(hold4), 32'd1);
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 4; i++) begin
                bb[i]   = dir_bytes[4*w + i];
                gaps[i] = 0;
            end
            send_word(w, dir_words[w]);
        end
        finish_session("full");
        chk("full_nwrites", 32'(wt4.size()), 32'd4);
        if (wt4.size() == 4) begin
            for (int i = 0; i < 3; i++) chk("full_spacing", 32'(wt4[i+1] - wt4[i]), 32'd5);
        end
        chk("hold_waddr", 32'(waddr4), 32'd3);
        chk("hold_wdata", wdata4, 32'h14002828);

        // Stall: valid pattern 1,0,0,1 inside word 0, then random gaps.
        pulse_start;
        for (int i = 0; i < 4; i++) bb[i] = 8'($urandom);
        gaps = '{0, 2, 0, 0};
        send_word(0, {bb[0], bb[1], bb[2], bb[3]});
        for (int w = 1; w < 4; w++) rand_word(w, 3);
        finish_session("stall");

        // Abort after 2 bytes of word 1, with a byte offered in the same cycle.
        pulse_start;
        rand_word(0, 1);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        d0 = done_cnt4;
        abort = 1'b1; byte_valid = 1'b1; byte_in = 8'h5A;
        tick;
        abort = 1'b0; byte_valid = 1'b0;
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_ready", 32'(rdy4), 32'd0);
        tick; tick;
        chk("abort_no_done", 32'(done_cnt4 - d0), 32'd0);
        pulse_start;
        for (int w = 0; w < 4; w++) rand_word(w, 1);
        finish_session("after_abort");

        // Abort sampled in WRITE: that cycle's write still completes.
        pulse_start;
        rand_word(0, 0);
        chk("wabort_we", 32'(we4), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("wabort_busy", 32'(busy4), 32'd0);
        chk("wabort_pending", 32'(q4.size()), 32'd0);
        tick; tick;

        // Asynchronous reset mid-session after 3 words.
        pulse_start;
        for (int w = 0; w < 3; w++) rand_word(w, 0);
        send_byte(8'hC3, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", 32'(we4), 32'd0);
        chk("arst_waddr", 32'(waddr4), 32'd0);
        chk("arst_wdata", wdata4, 32'd0);
        chk("arst_ready", 32'(rdy4), 32'd0);
        chk("arst_busy", 32'(busy4), 32'd0);
        chk("arst_hold", 32'(hold4), 32'd0);
        chk("arst_done", 32'(done4), 32'd0);
        #1 rst = 1'b0;
        byte_valid = 1'b1; byte_in = 8'h77;
        tick; tick; tick;
        chk("post_rst_ready", 32'(rdy4), 32'd0);
        chk("post_rst_busy", 32'(busy4), 32'd0);
        byte_valid = 1'b0;
        pulse_start;
        for (int w = 0; w < 4; w++) rand_word(w, 2);
        finish_session("after_rst");

        // Start pulsed mid-word is ignored.
        w0 = wr_cnt4;
        pulse_start;
        rand_word(0, 0);
        for (int i = 0; i < 4; i++) begin
            bb[i]   = 8'($urandom);
            gaps[i] = 0;
        end
        send_byte(bb[0], 0);
        start4 = 1'b1;
        send_byte(bb[1], 0);
        start4 = 1'b0;
        send_byte(bb[2], 0);
        send_byte(bb[3], 0);
        q4.push_back({6'd1, bb[0], bb[1], bb[2], bb[3]});
        rand_word(2, 1);
        rand_word(3, 1);
        finish_session("ign_start");
        chk("ign_start_nwrites", 32'(wr_cnt4 - w0), 32'd4);

        // Random sessions.
        for (int s = 0; s < 3; s++) begin
            pulse_start;
            for (int w = 0; w < 4; w++) rand_word(w, 2);
            finish_session("rand");
        end

        // 64-word boundary on the second instance.
        sel64 = 1'b1;
        chk("u64_idle_before", 32'(wr_cnt64), 32'd0);
        pulse_start;
        for (int w = 0; w < 64; w++) rand_word(w, (w % 8 == 0) ? 1 : 0);
        e64 = 38'd0;
        finish_session("n64");
        chk("n64_nwrites", 32'(wr_cnt64), 32'd64);
        chk("n64_last_waddr", 32'(waddr64), 32'h3F);
        for (int i = 0; i < 5; i++) tick;
        chk("n64_no_extra", 32'(wr_cnt64), 32'd64);
        chk("u4_untouched", 32'(busy4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
